minterm_sweeper: RTL and testbench
==================================

# minterm_sweeper

Sequential stimulus-and-check stage that sits directly upstream of the 4-input F1/F2 gate-level and data-flow circuits. On a start request it drives every input combination ABCD = 0000..1111 onto the circuit inputs, captures the returned F1/F2 values into 16-bit truth-table signatures, and compares them against the expected minterm sets. It reports pass/fail and per-minterm mismatch masks.

## Interface
Parameters:
- SETTLE, default 1: number of extra cycles each vector is held before sampling (0..15).
- EXP_F1, default 16'h0F5F: expected F1 minterm mask (minterms 0,1,2,3,4,6,8,9,10,11).
- EXP_F2, default 16'hADA8: expected F2 minterm mask (minterms 3,5,7,8,10,11,13,15).

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: sweep request; sampled only in IDLE.
- A, B, C, D  out  1 each: stimulus vector; A = idx[3] (MSB), D = idx[0].
- f1_in  in  1: F1 returned by the circuit under test.
- f2_in  in  1: F2 returned by the circuit under test.
- busy  out  1: sweep in progress.
- done  out  1: one-cycle pulse when results become valid.
- pass  out  1: both signatures equal their expected masks.
- f1_sig, f2_sig  out  16: captured truth tables; bit i = response to vector i.
- f1_mismatch, f2_mismatch  out  16: f*_sig XOR EXP_F*.

## Operation
- States: IDLE, RUN, CHECK.
- IDLE:
  - A..D = 0.
  - busy = 0.
  - Previous results are held.
  - When start = 1, go to RUN with idx = 0 and cnt = 0, and clear f1_sig and f2_sig.
- RUN:
  - A..D = idx.
  - At each edge: if cnt == SETTLE, write f1_sig[idx] <= f1_in and f2_sig[idx] <= f2_in, set cnt <= 0, and advance idx. Otherwise cnt <= cnt + 1.
  - Capturing at idx = 15 moves the state to CHECK. idx does not wrap; it stays at 15.
- CHECK:
  - One cycle.
  - Register the mismatch masks and pass.
  - Pulse done and return to IDLE.
- Reset: every output and internal register goes to 0, state goes to IDLE. This applies mid-sweep: a partial sweep is discarded and no done pulse is produced.
- Simultaneous events:
  - start while busy or in CHECK is ignored; it is not queued.
  - If rst and start are both high, rst wins.
- Results (sig, mismatch, pass) remain stable from the done pulse until the next accepted start.
- idx is a 4-bit counter; cnt is a 4-bit counter.

## Timing
- Edge k samples start = 1 in IDLE. busy is high from after edge k until edge k + 16·(SETTLE+1) + 1.
- Each vector is presented for SETTLE+1 cycles. Sampling happens at the last edge of that window, which gives combinational DUTs SETTLE+1 cycles to settle.
- done is high for exactly one cycle, after edge k + 16·(SETTLE+1) + 1. pass and the mismatch masks are valid in that same cycle.
- busy deasserts in the same cycle that done asserts.
- Total latency from start to done:
  - SETTLE = 1: 33 cycles.
  - SETTLE = 0: 17 cycles.
- A new start is accepted in the cycle done is high, because the state is already IDLE.

## Structure
- Shared package `minterm_pkg`:
  - State enum {IDLE, RUN, CHECK}.
  - Constants F1_MINTERMS = 16'h0F5F and F2_MINTERMS = 16'hADA8, used as the parameter defaults and by the bench.
- One sub-module, `minterm_capture`:
  - 16-bit indexed capture register with synchronous clear, 4-bit write index and write enable.
  - Instantiated twice, once for F1 and once for F2.
- The FSM, idx/cnt counters and compare logic live in the top module.
- The circuits under test are not instantiated inside the block.

## Test plan
- Correct F1 (B' + A'D') and F2 (BD + CD + AB'D') connected, SETTLE = 1, start pulsed: done at cycle 33 with f1_sig = 16'h0F5F, f2_sig = 16'hADA8, pass = 1, and both mismatch masks 0. A..D must step through 0..15, each value held for 2 cycles.
- f1_in stuck at 0: f1_mismatch = 16'h0F5F, f2_mismatch = 0, pass = 0.
- f2_in inverted only at vector 13 (ABCD = 1101): f2_sig = 16'h8DA8, f2_mismatch = 16'h2000, pass = 0.
- rst asserted while idx = 7:
  - Next cycle: A..D = 0, busy = 0, and sig/mismatch/pass = 0.
  - No done pulse.
  - A following start produces a full 33-cycle sweep with pass = 1.
- start re-pulsed at cycles 5 and 20 of a sweep: ignored, with a single done at cycle 33. A start in the done cycle begins a new sweep immediately.
- SETTLE = 0 with correct circuits: done at cycle 17, pass = 1, and each vector held for exactly 1 cycle.

Source files
------------

// File: rtl/minterm_pkg.sv
// Shared types and constants for the F1/F2 minterm sweeper and its bench.
// Expected truth tables are indexed by ABCD, so bit i is the response to vector i.
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // F1 = B' + A'D'      -> minterms 0,1,2,3,4,6,8,9,10,11
    localparam logic [15:0] F1_MINTERMS = 16'h0F5F;
    // F2 = BD + CD + AB'D' -> minterms 3,5,7,8,10,11,13,15
    localparam logic [15:0] F2_MINTERMS = 16'hADA8;

    localparam logic [3:0] LAST_VEC = 4'hF;

endpackage

// File: rtl/minterm_capture.sv
// 16-entry single-bit capture register: one truth-table signature.
// Reset and clear both empty it; clear wins over a write in the same cycle.
module minterm_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic        bit_in,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sig <= '0;
        end else if (wr_en) begin
            sig[wr_idx] <= bit_in;
        end
    end

endmodule

// File: rtl/minterm_sweeper.sv
// Drives ABCD = 0..15 into a 4-input circuit, captures F1/F2 into signatures
// and compares them with the expected minterm masks.
module minterm_sweeper
    import minterm_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] EXP_F1 = F1_MINTERMS,
    parameter logic [15:0] EXP_F2 = F2_MINTERMS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        f1_in,
    input  logic        f2_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] f1_sig,
    output logic [15:0] f2_sig,
    output logic [15:0] f1_mismatch,
    output logic [15:0] f2_mismatch,
    output state_t      fsm_state
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic [3:0] vec;
    logic       sample;
    logic       sig_clear;

    // start is a request with no ready: it is accepted only on an edge where
    // the state is IDLE, and busy high means any start is dropped, not queued.
    assign sig_clear = (state == IDLE) && start;
    assign sample    = (state == RUN) && (cnt == SETTLE_CNT);

    minterm_capture u_f1_cap (
        .clk    (clk),
        .rst    (rst),
        .clear  (sig_clear),
        .wr_en  (sample),
        .wr_idx (idx),
        .bit_in (f1_in),
        .sig    (f1_sig)
    );

    minterm_capture u_f2_cap (
        .clk    (clk),
        .rst    (rst),
        .clear  (sig_clear),
        .wr_en  (sample),
        .wr_idx (idx),
        .bit_in (f2_in),
        .sig    (f2_sig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            vec         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            f1_mismatch <= '0;
            f2_mismatch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        idx   <= '0;
                        cnt   <= '0;
                        vec   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == SETTLE_CNT) begin
                        cnt <= '0;
                        // idx parks at the last vector; the stimulus returns to 0
                        if (idx == LAST_VEC) begin
                            state <= CHECK;
                            vec   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                            vec <= idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK: begin
                    f1_mismatch <= f1_sig ^ EXP_F1;
                    f2_mismatch <= f2_sig ^ EXP_F2;
                    pass        <= (f1_sig == EXP_F1) && (f2_sig == EXP_F2);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {A, B, C, D} = vec;
    assign fsm_state    = state;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench for minterm_sweeper: SETTLE=1 and SETTLE=0 instances driven by
// behavioural F1/F2 circuits with optional stuck/flip faults.
module tb_minterm_sweeper;
    import minterm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic rst0, rst1, start0, start1;
    logic a0, b0, c0, d0, a1, b1, c1, d1;
    logic f1_0, f2_0, f1_1, f2_1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] sig1_0, sig2_0, mm1_0, mm2_0;
    logic [15:0] sig1_1, sig2_1, mm1_1, mm2_1;
    state_t st0, st1;
    logic [3:0] vec0, vec1;

    logic sel = 1'b0;
    logic f1_stuck = 1'b0;
    logic f2_flip13 = 1'b0;

    minterm_sweeper #(.SETTLE(1)) dut0 (
        .clk(clk), .rst(rst0), .start(start0),
        .A(a0), .B(b0), .C(c0), .D(d0),
        .f1_in(f1_0), .f2_in(f2_0),
        .busy(busy0), .done(done0), .pass(pass0),
        .f1_sig(sig1_0), .f2_sig(sig2_0),
        .f1_mismatch(mm1_0), .f2_mismatch(mm2_0),
        .fsm_state(st0)
    );

    minterm_sweeper #(.SETTLE(0)) dut1 (
        .clk(clk), .rst(rst1), .start(start1),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .f1_in(f1_1), .f2_in(f2_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .f1_sig(sig1_1), .f2_sig(sig2_1),
        .f1_mismatch(mm1_1), .f2_mismatch(mm2_1),
        .fsm_state(st1)
    );

    // Circuits under test, v = {A,B,C,D}
    function automatic logic cut_f1(input logic [3:0] v);
        return ~v[2] | (~v[3] & ~v[0]);
    endfunction

    function automatic logic cut_f2(input logic [3:0] v);
        return (v[2] & v[0]) | (v[1] & v[0]) | (v[3] & ~v[2] & ~v[0]);
    endfunction

    assign vec0 = {a0, b0, c0, d0};
    assign vec1 = {a1, b1, c1, d1};
    assign f1_0 = f1_stuck ? 1'b0 : cut_f1(vec0);
    assign f2_0 = cut_f2(vec0) ^ (f2_flip13 && (vec0 == 4'd13));
    assign f1_1 = cut_f1(vec1);
    assign f2_1 = cut_f2(vec1);

    // Views of whichever instance is under test
    logic [3:0]  w_vec;
    logic        w_busy, w_done, w_pass;
    logic [15:0] w_sig1, w_sig2, w_mm1, w_mm2, w_st;
    assign w_vec  = sel ? vec1   : vec0;
    assign w_busy = sel ? busy1  : busy0;
    assign w_done = sel ? done1  : done0;
    assign w_pass = sel ? pass1  : pass0;
    assign w_sig1 = sel ? sig1_1 : sig1_0;
    assign w_sig2 = sel ? sig2_1 : sig2_0;
    assign w_mm1  = sel ? mm1_1  : mm1_0;
    assign w_mm2  = sel ? mm2_1  : mm2_0;
    assign w_st   = sel ? 16'(st1) : 16'(st0);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Called at a negedge; pulses start and follows the sweep to its done cycle.
    task automatic sweep(input string tag, input int lat, input int hold,
                         input logic [15:0] es1, input logic [15:0] es2,
                         input logic [15:0] em1, input logic [15:0] em2,
                         input logic ep, input bit repulse);
        logic [3:0] ev;
        drive_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_start(1'b0);
        for (int j = 0; j <= lat; j++) begin
            if (j > 0) begin
                @(posedge clk);
                @(negedge clk);
                drive_start(1'b0);
            end
            ev = (j <= lat - 2) ? 4'(j / hold) : 4'd0;
            check($sformatf("%s_vec_c%0d", tag, j), 16'(w_vec), 16'(ev));
            check($sformatf("%s_busy_c%0d", tag, j), 16'(w_busy), 16'(j < lat));
            check($sformatf("%s_done_c%0d", tag, j), 16'(w_done), 16'(j == lat));
            if (repulse && (j == 5 || j == 20)) drive_start(1'b1);
        end
        check({tag, "_state"}, w_st, 16'(IDLE));
        check({tag, "_f1_sig"}, w_sig1, es1);
        check({tag, "_f2_sig"}, w_sig2, es2);
        check({tag, "_f1_mm"}, w_mm1, em1);
        check({tag, "_f2_mm"}, w_mm2, em2);
        check({tag, "_pass"}, 16'(w_pass), 16'(ep));
    endtask

    initial begin
        int done_seen;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        check("rst_vec", 16'(vec0), 16'h0);
        check("rst_busy", 16'(busy0), 16'h0);
        check("rst_done", 16'(done0), 16'h0);
        check("rst_pass", 16'(pass0), 16'h0);
        check("rst_sig", sig1_0 | sig2_0, 16'h0);
        check("rst_mm", mm1_0 | mm2_0, 16'h0);
        check("rst_state", 16'(st0), 16'(IDLE));

        // Correct circuits, start re-pulsed mid-sweep, then restart in the done cycle
        sweep("good_repulse", 33, 2, 16'h0F5F, 16'hADA8, 16'h0, 16'h0, 1'b1, 1'b1);
        sweep("good_chain", 33, 2, 16'h0F5F, 16'hADA8, 16'h0, 16'h0, 1'b1, 1'b0);

        f1_stuck = 1'b1;
        sweep("f1_stuck0", 33, 2, 16'h0000, 16'hADA8, 16'h0F5F, 16'h0, 1'b0, 1'b0);
        f1_stuck = 1'b0;

        f2_flip13 = 1'b1;
        sweep("f2_flip13", 33, 2, 16'h0F5F, 16'h8DA8, 16'h0, 16'h2000, 1'b0, 1'b0);
        f2_flip13 = 1'b0;

        // Reset while vector 7 is on the bus
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_vec7", 16'(vec0), 16'd7);
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        check("mid_rst_vec", 16'(vec0), 16'h0);
        check("mid_rst_busy", 16'(busy0), 16'h0);
        check("mid_rst_f1_sig", sig1_0, 16'h0);
        check("mid_rst_f2_sig", sig2_0, 16'h0);
        check("mid_rst_f2_mm", mm2_0, 16'h0);
        check("mid_rst_pass", 16'(pass0), 16'h0);
        check("mid_rst_state", 16'(st0), 16'(IDLE));
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) done_seen++;
        end
        check("mid_rst_no_done", 16'(done_seen), 16'h0);

        sweep("after_rst", 33, 2, 16'h0F5F, 16'hADA8, 16'h0, 16'h0, 1'b1, 1'b0);

        sel = 1'b1;
        sweep("settle0", 17, 1, 16'h0F5F, 16'hADA8, 16'h0, 16'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
